// File: rtl/pr_gate_pkg.sv
// Shared types and constants for the PR region isolation gate.
package pr_gate_pkg;

    localparam int unsigned TO_W = 16;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FROZEN
    } state_e;

    // Beat view at the default 64-bit data / 3-bit empty widths.
    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } st_beat_t;

endpackage

// File: rtl/st_pkt_tracker.sv
// In-packet flag for one Avalon-ST interface, driven by handshaked SOP/EOP beats.
module st_pkt_tracker (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic valid,
    input  logic ready,
    input  logic sop,
    input  logic eop,
    output logic in_pkt
);

    logic in_pkt_q, in_pkt_d;

    // A single-beat packet (sop & eop) takes the eop branch and never sets the flag.
    always_comb begin
        in_pkt_d = in_pkt_q;
        if (valid && ready) begin
            if (eop) begin
                in_pkt_d = 1'b0;
            end else if (sop) begin
                in_pkt_d = 1'b1;
            end
        end
        if (clear) begin
            in_pkt_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt_q <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
        end
    end

    assign in_pkt = in_pkt_q;

endmodule

// File: rtl/pr_region_gate.sv
// Avalon-ST isolation gate between the packet switch and one PR region.
// Define PR_GATE_STATS_EN to add the drop_pkts / trunc_pkts counters.
module pr_region_gate
    import pr_gate_pkg::*;
#(
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned EMPTY_W       = 3,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               region_enable,
    input  logic               region_freeze,
    output logic               freeze_ack,
`ifdef PR_GATE_STATS_EN
    output logic [31:0]        drop_pkts,
    output logic [31:0]        trunc_pkts,
`endif
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               in_ready,
    output logic [DATA_W-1:0]  rtx_data,
    output logic               rtx_valid,
    output logic               rtx_sop,
    output logic               rtx_eop,
    output logic [EMPTY_W-1:0] rtx_empty,
    input  logic               rtx_ready,
    input  logic [DATA_W-1:0]  rrx_data,
    input  logic               rrx_valid,
    input  logic               rrx_sop,
    input  logic               rrx_eop,
    input  logic [EMPTY_W-1:0] rrx_empty,
    output logic               rrx_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               out_error,
    input  logic               out_ready
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(DRAIN_TIMEOUT);

    state_e          state_q, state_d;
    logic            freeze_ack_q;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            drop_q, drop_d;
    logic            trunc_q, trunc_d;
    logic            err_sent_q, err_sent_d;

    logic in_pkt, rrx_pkt;
    logic trk_clear, timeout, drop_sop, trunc_evt, in_hs;

    assign in_hs     = in_valid & in_ready;
    assign trk_clear = (state_q == FROZEN) & ~region_freeze;
    assign timeout   = (state_q == DRAIN) && (to_cnt_q >= TO_LIMIT);
    assign drop_sop  = (state_q == RUN) & ~in_pkt & in_sop & ~region_enable;
    assign trunc_evt = timeout & ~trunc_q & (in_pkt | rrx_pkt);

    st_pkt_tracker u_in_trk (
        .clk    (clk),
        .reset  (reset),
        .clear  (trk_clear),
        .valid  (in_valid),
        .ready  (in_ready),
        .sop    (in_sop),
        .eop    (in_eop),
        .in_pkt (in_pkt)
    );

    st_pkt_tracker u_rrx_trk (
        .clk    (clk),
        .reset  (reset),
        .clear  (trk_clear),
        .valid  (rrx_valid),
        .ready  (rrx_ready),
        .sop    (rrx_sop),
        .eop    (rrx_eop),
        .in_pkt (rrx_pkt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (region_freeze) state_d = DRAIN;
            DRAIN:   if (!in_pkt && !rrx_pkt) state_d = FROZEN;
            FROZEN:  if (!region_freeze) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Held at zero outside DRAIN, so every DRAIN entry starts from zero.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == DRAIN) begin
            to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 16'd1;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (in_hs) begin
            if (in_eop) begin
                drop_d = 1'b0;
            end else if (drop_sop) begin
                drop_d = 1'b1;
            end
        end
        if (trk_clear) begin
            drop_d = 1'b0;
        end
    end

    always_comb begin
        trunc_d    = 1'b0;
        err_sent_d = 1'b0;
        if (state_q == DRAIN) begin
            trunc_d    = trunc_q | trunc_evt;
            err_sent_d = err_sent_q | (out_valid & out_ready & out_error);
        end
    end

    assign rtx_data  = in_data;
    assign rtx_sop   = in_sop;
    assign rtx_eop   = in_eop;
    assign rtx_empty = in_empty;

    always_comb begin
        in_ready  = 1'b0;
        rtx_valid = 1'b0;
        case (state_q)
            RUN: begin
                if (drop_q || drop_sop) begin
                    in_ready = 1'b1;
                end else begin
                    in_ready  = rtx_ready;
                    rtx_valid = in_valid;
                end
            end
            DRAIN: begin
                if (in_pkt) begin
                    if (drop_q || timeout) begin
                        in_ready = 1'b1;
                    end else begin
                        in_ready  = rtx_ready;
                        rtx_valid = in_valid;
                    end
                end
            end
            default: ;
        endcase
    end

    // After timeout an egress packet is closed with an error beat, then its tail is sunk.
    always_comb begin
        rrx_ready = 1'b0;
        out_valid = 1'b0;
        out_data  = rrx_data;
        out_sop   = rrx_sop;
        out_eop   = rrx_eop;
        out_empty = rrx_empty;
        out_error = 1'b0;
        case (state_q)
            RUN: begin
                rrx_ready = out_ready;
                out_valid = rrx_valid;
            end
            DRAIN: begin
                if (rrx_pkt) begin
                    if (!timeout) begin
                        rrx_ready = out_ready;
                        out_valid = rrx_valid;
                    end else if (!err_sent_q) begin
                        out_valid = 1'b1;
                        out_data  = '0;
                        out_sop   = 1'b0;
                        out_eop   = 1'b1;
                        out_empty = '0;
                        out_error = 1'b1;
                    end else begin
                        rrx_ready = 1'b1;
                    end
                end
            end
            FROZEN:  rrx_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            freeze_ack_q <= 1'b0;
            to_cnt_q     <= '0;
            drop_q       <= 1'b0;
            trunc_q      <= 1'b0;
            err_sent_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            freeze_ack_q <= (state_d == FROZEN);
            to_cnt_q     <= to_cnt_d;
            drop_q       <= drop_d;
            trunc_q      <= trunc_d;
            err_sent_q   <= err_sent_d;
        end
    end

    assign freeze_ack = freeze_ack_q;

`ifdef PR_GATE_STATS_EN
    logic [31:0] drop_cnt_q, trunc_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (in_hs && drop_sop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
            if (trunc_evt && (trunc_cnt_q != '1)) begin
                trunc_cnt_q <= trunc_cnt_q + 32'd1;
            end
        end
    end

    assign drop_pkts  = drop_cnt_q;
    assign trunc_pkts = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_pr_region_gate.sv
// Self-checking bench for pr_region_gate: vector table plus freeze/drain/timeout sequences.
module tb_pr_region_gate;

    localparam int DW = 64;
    localparam int EW = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          region_enable, region_freeze, freeze_ack;
    logic [DW-1:0] in_data, rtx_data, rrx_data, out_data;
    logic          in_valid, in_sop, in_eop, in_ready;
    logic [EW-1:0] in_empty, rtx_empty, rrx_empty, out_empty;
    logic          rtx_valid, rtx_sop, rtx_eop, rtx_ready;
    logic          rrx_valid, rrx_sop, rrx_eop, rrx_ready;
    logic          out_valid, out_sop, out_eop, out_error, out_ready;
`ifdef PR_GATE_STATS_EN
    logic [31:0]   drop_pkts, trunc_pkts;
`endif

    always #5 clk = ~clk;

    pr_region_gate #(
        .DATA_W        (DW),
        .EMPTY_W       (EW),
        .DRAIN_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .region_enable (region_enable),
        .region_freeze (region_freeze),
        .freeze_ack    (freeze_ack),
`ifdef PR_GATE_STATS_EN
        .drop_pkts     (drop_pkts),
        .trunc_pkts    (trunc_pkts),
`endif
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_empty      (in_empty),
        .in_ready      (in_ready),
        .rtx_data      (rtx_data),
        .rtx_valid     (rtx_valid),
        .rtx_sop       (rtx_sop),
        .rtx_eop       (rtx_eop),
        .rtx_empty     (rtx_empty),
        .rtx_ready     (rtx_ready),
        .rrx_data      (rrx_data),
        .rrx_valid     (rrx_valid),
        .rrx_sop       (rrx_sop),
        .rrx_eop       (rrx_eop),
        .rrx_empty     (rrx_empty),
        .rrx_ready     (rrx_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .out_empty     (out_empty),
        .out_error     (out_error),
        .out_ready     (out_ready)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        error;
    } beat_t;

    // Fields: in_v in_s in_e en rtx_rdy | rrx_v rrx_s rrx_e out_rdy | x_in_rdy x_rtx_v x_rrx_rdy x_out_v
    typedef struct packed {
        logic in_v, in_s, in_e, en, rr;
        logic qv, qs, qe, orr;
        logic x_ir, x_rtv, x_rrr, x_ov;
    } vec_t;

    beat_t rtx_q[$];
    beat_t out_q[$];
    beat_t exp_r, exp_o;
    vec_t  vecs[13];
    vec_t  v;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        rrx_valid = 1'b0;
        rrx_sop   = 1'b0;
        rrx_eop   = 1'b0;
    endtask

    task automatic drive_in(input logic sop, input logic eop);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = {$urandom(), $urandom()};
        in_empty = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_rrx(input logic sop, input logic eop);
        rrx_valid = 1'b1;
        rrx_sop   = sop;
        rrx_eop   = eop;
        rrx_data  = {$urandom(), $urandom()};
        rrx_empty = 3'($urandom_range(0, 7));
    endtask

    task automatic exp_in(input logic x_rdy, input logic x_val, input string tag);
        chk({tag, "_in_ready"}, in_ready, x_rdy);
        chk({tag, "_rtx_valid"}, rtx_valid, x_val);
        if (x_val && rtx_ready) rtx_q.push_back({in_data, in_sop, in_eop, in_empty, 1'b0});
    endtask

    task automatic exp_rrx(input logic x_rdy, input logic x_val, input string tag);
        chk({tag, "_rrx_ready"}, rrx_ready, x_rdy);
        chk({tag, "_out_valid"}, out_valid, x_val);
        if (x_val && out_ready) out_q.push_back({rrx_data, rrx_sop, rrx_eop, rrx_empty, 1'b0});
    endtask

    always @(negedge clk) begin
        if (!reset && rtx_valid && rtx_ready) begin
            chk("rtx_beat_expected", 64'(rtx_q.size() != 0), 1);
            if (rtx_q.size() != 0) begin
                exp_r = rtx_q.pop_front();
                chk("rtx_data", rtx_data, exp_r.data);
                chk("rtx_sop_eop", {rtx_sop, rtx_eop}, {exp_r.sop, exp_r.eop});
                chk("rtx_empty", rtx_empty, exp_r.empty);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            chk("out_beat_expected", 64'(out_q.size() != 0), 1);
            if (out_q.size() != 0) begin
                exp_o = out_q.pop_front();
                chk("out_data", out_data, exp_o.data);
                chk("out_sop_eop", {out_sop, out_eop}, {exp_o.sop, exp_o.eop});
                chk("out_empty", out_empty, exp_o.empty);
                chk("out_error", out_error, exp_o.error);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack;
        int first_ack;
        int w;

        vecs[0]  = 13'b11011_1101_1111;
        vecs[1]  = 13'b10011_1001_1111;
        vecs[2]  = 13'b10111_1011_1111;
        vecs[3]  = 13'b00011_0001_1010;
        vecs[4]  = 13'b11001_1110_1001;
        vecs[5]  = 13'b10011_1111_1011;
        vecs[6]  = 13'b10010_0000_1000;
        vecs[7]  = 13'b10111_0001_1010;
        vecs[8]  = 13'b11010_0001_0110;
        vecs[9]  = 13'b11011_0001_1110;
        vecs[10] = 13'b10101_0001_1110;
        vecs[11] = 13'b11101_0001_1010;
        vecs[12] = 13'b11111_0001_1110;

        reset         = 1'b1;
        region_enable = 1'b1;
        region_freeze = 1'b0;
        rtx_ready     = 1'b0;
        out_ready     = 1'b0;
        in_data       = '0;
        in_empty      = '0;
        rrx_data      = '0;
        rrx_empty     = '0;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        tick();
        rtx_ready = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("rst_freeze_ack", freeze_ack, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rrx_ready", rrx_ready, 1);
        chk("rst_rtx_valid", rtx_valid, 0);
        chk("rst_out_valid", out_valid, 0);
`ifdef PR_GATE_STATS_EN
        chk("rst_drop_pkts", drop_pkts, 0);
        chk("rst_trunc_pkts", trunc_pkts, 0);
`endif

        // RUN pass-through and enable=0 dropping
        for (int i = 0; i < 13; i++) begin
            tick();
            v = vecs[i];
            drive_in(v.in_s, v.in_e);
            in_valid      = v.in_v;
            region_enable = v.en;
            rtx_ready     = v.rr;
            drive_rrx(v.qs, v.qe);
            rrx_valid     = v.qv;
            out_ready     = v.orr;
            #2;
            chk($sformatf("vec%0d_in_ready", i), in_ready, v.x_ir);
            chk($sformatf("vec%0d_rtx_valid", i), rtx_valid, v.x_rtv);
            chk($sformatf("vec%0d_rrx_ready", i), rrx_ready, v.x_rrr);
            chk($sformatf("vec%0d_out_valid", i), out_valid, v.x_ov);
            chk($sformatf("vec%0d_out_error", i), out_error, 0);
            if (v.x_rtv && v.rr) rtx_q.push_back({in_data, in_sop, in_eop, in_empty, 1'b0});
            if (v.x_ov && v.orr) out_q.push_back({rrx_data, rrx_sop, rrx_eop, rrx_empty, 1'b0});
        end
`ifdef PR_GATE_STATS_EN
        tick();
        idle_inputs();
        #2;
        chk("drop_pkts_after_table", drop_pkts, 2);
`endif

        // Freeze at beat 2 of a 5-beat packet
        tick();
        idle_inputs();
        region_enable = 1'b1;
        rtx_ready     = 1'b1;
        out_ready     = 1'b1;
        drive_in(1'b1, 1'b0);
        #2;
        exp_in(1, 1, "frz_b1");
        tick();
        region_freeze = 1'b1;
        drive_in(1'b0, 1'b0);
        #2;
        exp_in(1, 1, "frz_b2");
        for (int b = 3; b <= 5; b++) begin
            tick();
            drive_in(1'b0, b == 5);
            #2;
            exp_in(1, 1, $sformatf("frz_b%0d", b));
            chk($sformatf("frz_b%0d_ack", b), freeze_ack, 0);
        end
        tick();
        drive_in(1'b1, 1'b0);
        drive_rrx(1'b1, 1'b0);
        #2;
        exp_in(0, 0, "drain_new_sop");
        exp_rrx(0, 0, "drain_new_rrx_sop");
        chk("drain_idle_ack", freeze_ack, 0);
        tick();
        #2;
        chk("frozen_ack", freeze_ack, 1);
        exp_in(0, 0, "frozen_in");

        // FROZEN: rrx beats are sunk, nothing reaches out
        for (int i = 0; i < 6; i++) begin
            tick();
            idle_inputs();
            drive_rrx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rrx_valid = i[0];
            #2;
            exp_rrx(1, 0, $sformatf("frozen_rrx%0d", i));
            chk($sformatf("frozen_ack%0d", i), freeze_ack, 1);
        end
        tick();
        idle_inputs();
        region_freeze = 1'b0;
        #2;
        chk("unfreeze_ack_still", freeze_ack, 1);
        tick();
        drive_in(1'b1, 1'b1);
        drive_rrx(1'b1, 1'b1);
        #2;
        chk("run_again_ack", freeze_ack, 0);
        exp_in(1, 1, "run_again");
        exp_rrx(1, 1, "run_again");

        // One-cycle freeze pulse while idle
        tick();
        idle_inputs();
        region_freeze = 1'b1;
        #2;
        chk("pulse_ack_before", freeze_ack, 0);
        n_ack     = 0;
        first_ack = -1;
        for (int i = 0; i < 5; i++) begin
            tick();
            idle_inputs();
            region_freeze = 1'b0;
            if (i == 0) drive_in(1'b1, 1'b1);
            #2;
            if (i == 0) exp_in(0, 0, "pulse_drain");
            if (freeze_ack) begin
                n_ack++;
                if (first_ack < 0) first_ack = i;
            end
        end
        chk("pulse_ack_cycles", n_ack, 1);
        chk("pulse_ack_position", first_ack, 1);

        // Drain timeout with both paths stuck mid-packet
        tick();
        idle_inputs();
        region_freeze = 1'b1;
        rtx_ready     = 1'b1;
        out_ready     = 1'b1;
        drive_in(1'b1, 1'b0);
        drive_rrx(1'b1, 1'b0);
        #2;
        exp_in(1, 1, "to_sop");
        exp_rrx(1, 1, "to_sop");
        for (int k = 1; k <= 8; k++) begin
            tick();
            idle_inputs();
            rtx_ready = 1'b0;
            drive_in(1'b0, 1'b0);
            #2;
            exp_in(0, 1, $sformatf("to_wait%0d", k));
            chk($sformatf("to_wait%0d_out_valid", k), out_valid, 0);
        end
        tick();
        drive_in(1'b0, 1'b0);
        out_ready = 1'b0;
        #2;
        exp_in(1, 0, "to_c9");
        chk("to_c9_out_valid", out_valid, 1);
        chk("to_c9_err_beat", {out_sop, out_eop, out_error}, 3'b011);
        chk("to_c9_err_data", out_data, 0);
        chk("to_c9_err_empty", out_empty, 0);
        chk("to_c9_rrx_ready", rrx_ready, 0);
        tick();
        drive_in(1'b0, 1'b0);
        out_ready = 1'b1;
        #2;
        chk("to_c10_out_valid", out_valid, 1);
        out_q.push_back({64'h0, 1'b0, 1'b1, 3'h0, 1'b1});
        tick();
        idle_inputs();
        drive_rrx(1'b0, 1'b0);
        #2;
        exp_rrx(1, 0, "to_sink_mid");
        tick();
        drive_in(1'b0, 1'b1);
        drive_rrx(1'b0, 1'b1);
        #2;
        exp_in(1, 0, "to_sink_eop");
        exp_rrx(1, 0, "to_sink_eop");
        w = 0;
        do begin
            tick();
            idle_inputs();
            #2;
            w++;
        end while (!freeze_ack && w < 6);
        chk("to_frozen_ack", freeze_ack, 1);
        chk("to_frozen_latency", w, 2);
`ifdef PR_GATE_STATS_EN
        chk("trunc_pkts", trunc_pkts, 1);
        chk("drop_pkts_final", drop_pkts, 2);
`endif
        tick();
        region_freeze = 1'b0;
        tick();
        #2;
        chk("to_release_ack", freeze_ack, 0);

        // Reset in the middle of a dropped packet clears the drop decision
        tick();
        rtx_ready     = 1'b1;
        region_enable = 1'b0;
        drive_in(1'b1, 1'b0);
        #2;
        exp_in(1, 0, "rst_mid_drop");
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
        region_enable = 1'b1;
        drive_in(1'b1, 1'b1);
        #2;
        exp_in(1, 1, "rst_mid_after");
        chk("rst_mid_ack", freeze_ack, 0);

        tick();
        idle_inputs();
        tick();
        tick();
        chk("rtx_queue_drained", rtx_q.size(), 0);
        chk("out_queue_drained", out_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
